// File: rtl/logic_unit_pipe.sv
// One-stage bitwise logic unit with valid/ready handshake, result flags and beat counter.
// Optional accumulator operand source is compiled in with LOGIC_UNIT_ACC_EN.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] txn_cnt
);

    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] result;

    // The result register frees up in the same cycle it is drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef LOGIC_UNIT_ACC_EN
    logic [WIDTH-1:0] acc;

    assign b_eff = use_acc ? acc : b;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (accept) begin
            acc <= result;
        end
    end
`else
    logic unused_use_acc;

    assign unused_use_acc = use_acc;
    assign b_eff          = b;
`endif

    always_comb begin
        result = a;
        case (op)
            3'b000: result = ~a;
            3'b001: result = a & b_eff;
            3'b010: result = a | b_eff;
            3'b011: result = a ^ b_eff;
            3'b100: result = ~(a & b_eff);
            3'b101: result = ~(a | b_eff);
            3'b110: result = ~(a ^ b_eff);
            default: result = a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b1;
            parity    <= 1'b0;
            txn_cnt   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= result;
            zero      <= (result == '0);
            parity    <= ^result;
            txn_cnt   <= txn_cnt + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: vector table, handshake corner sequences,
// and randomized traffic against a truth-table reference model with a delivery scoreboard.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic       use_acc;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       zero;
    logic       parity;
    logic [7:0] txn_cnt;

    int errors = 0;
    int checks = 0;

    logic       m_valid;
    logic [7:0] m_y;
    logic [7:0] m_cnt;
    logic [7:0] m_acc;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       z;
        logic       p;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .use_acc  (use_acc),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .zero     (zero),
        .parity   (parity),
        .txn_cnt  (txn_cnt)
    );

    // Each op is a 2-input truth table applied per bit; table bit index is {a_bit, b_bit}.
    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
        logic [3:0] tt;
        logic [7:0] r;
        case (o)
            3'd0: tt = 4'b0011;
            3'd1: tt = 4'b1000;
            3'd2: tt = 4'b1110;
            3'd3: tt = 4'b0110;
            3'd4: tt = 4'b0111;
            3'd5: tt = 4'b0001;
            3'd6: tt = 4'b1001;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 8; i++) r[i] = tt[{x[i], z[i]}];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst, input logic iv, input logic ordy, input logic [2:0] o,
                         input logic ua, input logic [7:0] xa, input logic [7:0] xb);
        logic       rdy;
        logic       take;
        logic [7:0] beff;
        logic [7:0] res;
        reset     = rst;
        in_valid  = iv;
        out_ready = ordy;
        op        = o;
        use_acc   = ua;
        a         = xa;
        b         = xb;
        #1;
        rdy = !m_valid || ordy;
        if (!rst) begin
            check("in_ready", in_ready, rdy);
            if (out_valid && ordy) begin
                check("deliver_pending", sb_q.size(), 1);
                if (sb_q.size() > 0) check("deliver_y", y, sb_q.pop_front());
            end
        end
`ifdef LOGIC_UNIT_ACC_EN
        beff = ua ? m_acc : xb;
`else
        beff = xb;
`endif
        res  = ref_op(o, xa, beff);
        take = iv && rdy;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_y     = 8'h00;
            m_cnt   = 8'h00;
            m_acc   = 8'h00;
            sb_q.delete();
        end else if (take) begin
            m_valid = 1'b1;
            m_y     = res;
            m_cnt   = m_cnt + 8'd1;
            m_acc   = res;
            sb_q.push_back(res);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("y", y, m_y);
        check("zero", zero, m_y == 8'h00);
        check("parity", parity, ^m_y);
        check("txn_cnt", txn_cnt, m_cnt);
    endtask

    initial begin
        vecs[0] = '{3'b001, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[1] = '{3'b000, 8'hA5, 8'h0F, 8'h5A, 1'b0, 1'b0};
        vecs[2] = '{3'b001, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0};
        vecs[3] = '{3'b010, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0};
        vecs[4] = '{3'b011, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0};
        vecs[5] = '{3'b100, 8'hA5, 8'h0F, 8'hFA, 1'b0, 1'b0};
        vecs[6] = '{3'b101, 8'hA5, 8'h0F, 8'h50, 1'b0, 1'b0};
        vecs[7] = '{3'b110, 8'hA5, 8'h0F, 8'h55, 1'b0, 1'b0};
        vecs[8] = '{3'b111, 8'hA5, 8'h0F, 8'hA5, 1'b0, 1'b0};
        vecs[9] = '{3'b011, 8'h77, 8'h77, 8'h00, 1'b1, 1'b0};

        m_valid = 1'b0;
        m_y     = 8'h00;
        m_cnt   = 8'h00;
        m_acc   = 8'h00;

        cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 3'd7, 1'b0, 8'hFF, 8'hFF);
        check("rst_out_valid", out_valid, 0);
        check("rst_zero", zero, 1);

        // Table vectors: one beat per cycle with the consumer always ready.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1, vecs[i].op, 1'b0, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_y", i), y, vecs[i].y);
            check($sformatf("vec%0d_zero", i), zero, vecs[i].z);
            check($sformatf("vec%0d_parity", i), parity, vecs[i].p);
            if (i == 0) check("vec0_txn_cnt", txn_cnt, 1);
        end

        // Backpressure: first beat held, second stalled until out_ready rises.
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 3'b001, 1'b0, 8'hFF, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 8'hF0, 8'h01);
            check("bp_hold_y", y, 8'h0F);
            check("bp_in_ready_low", in_ready, 0);
        end
        cycle(1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 8'hF0, 8'h01);
        check("bp_second_y", y, 8'hF1);
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 8'h00);
        check("bp_drained", out_valid, 0);

        // Accumulator operand source.
        cycle(1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 8'h0F, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 3'b010, 1'b1, 8'hF0, 8'h00);
`ifdef LOGIC_UNIT_ACC_EN
        check("acc_or_y", y, 8'hFF);
`else
        check("acc_or_y", y, 8'hF0);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0), 3'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom));
        end

        // Counter wrap after 256 accepts from reset.
        cycle(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 3'b011, 1'b0, 8'h77, 8'h77);
            if (i == 0) check("xor_self_zero", zero, 1);
            if (i == 254) check("cnt_255", txn_cnt, 255);
        end
        check("cnt_wrap", txn_cnt, 0);

        // Reset while a result is stuck under backpressure.
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 8'hAB, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 8'hCD, 8'h00);
        check("pre_rst_y", y, 8'hAB);
        cycle(1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 8'hCD, 8'h00);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_y", y, 0);
        check("post_rst_zero", zero, 1);
        check("post_rst_cnt", txn_cnt, 0);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
